tx_link_arbiter: RTL and testbench
==================================

// Module: tx_link_arbiter
// PURPOSE
//  Shares the single-bit serial TX link between NUM_REQ parallel-word clients.
//  Grants requesters round-robin and frames each word as {source ID, data}.
//  Serializes the frame MSB first under rx_ready backpressure and pulses
//  tx_finish per frame. Sits between client logic and the receiver, on the
//  same rx_ready / tx_data / tx_valid / tx_finish link as the standalone tx.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  DATA_W   8  payload bits per request
//  ID_W     $clog2(NUM_REQ)  source-ID field width (derived, localparam)
//  FRAME_W  ID_W+DATA_W      serialized frame length (derived, localparam)
// PORTS
//  clk        in   1                clock, all state on posedge
//  rst_n      in   1                asynchronous active-low reset
//  req_valid  in   NUM_REQ          per-requester word available
//  req_data   in   NUM_REQ*DATA_W   packed payloads, requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          one-hot accept; transfer when valid&ready
//  rx_ready   in   1                receiver accepts current bit
//  tx_data    out  1                serial bit, MSB of frame first
//  tx_valid   out  1                tx_data is a valid frame bit
//  tx_finish  out  1                1-cycle pulse after last bit accepted
//  tx_src     out  ID_W             ID of frame in flight (held through DONE)
//  busy       out  1                state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert by upstream): state=IDLE.
//   - tx_data, tx_valid, tx_finish, tx_src, busy and shreg/bit count = 0.
//   - RR pointer = 0.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE, arbitration:
//   - grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo NUM_REQ.
//   - req_ready[grant]=1 combinationally, only in IDLE; all other req_ready=0.
//   - On grant, the next edge:
//       shreg <= {grant[ID_W-1:0], req_data[grant]}; cnt <= 0; tx_src <= grant;
//       ptr <= (grant==NUM_REQ-1) ? 0 : grant+1; state <= SHIFT.
//   - No req_valid: stay in IDLE, ptr unchanged. rx_ready is ignored in IDLE.
//  SHIFT:
//   - tx_valid=1 and tx_data=shreg[FRAME_W-1], both registered.
//   - Bit accepted on a cycle where tx_valid && rx_ready: shift left, cnt++.
//   - rx_ready=0: tx_data and tx_valid hold. tx_valid never drops mid-frame.
//   - Acceptance at cnt==FRAME_W-1: state <= DONE, tx_valid <= 0.
//  DONE: tx_finish=1 for exactly one cycle, then IDLE.
//   - No grant is issued in DONE, so there is a minimum 1-cycle gap between frames.
//  Latency with rx_ready held at 1:
//   - Grant cycle T; bits on T+1..T+FRAME_W; tx_finish high in T+FRAME_W+1.
//   - Next grant possible at T+FRAME_W+2.
//  Boundary cases:
//   - req_valid deasserting while a request is not granted loses nothing.
//   - Changing req_data for the in-flight requester after capture has no effect.
//   - rst_n low mid-frame aborts immediately: outputs go to reset values, no
//     tx_finish, and the partial frame is dropped.
//   - ptr wraps NUM_REQ-1 -> 0.
//   - Non-power-of-2 NUM_REQ: the ID field carries the grant index only.
// STRUCTURE
//  Package tx_pkg:
//   - typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_DONE} tx_state_e.
//   - frame-width helper function.
//  Sub-module tx_rr_arbiter:
//   - Combinational grant/one-hot from req_valid and ptr, plus the registered ptr.
//   - Reused by later multi-client link blocks.
//  Top holds the FSM, shift register, bit counter and output registers.
// TESTING
//  Defaults NUM_REQ=4, DATA_W=8, so FRAME_W=10.
//  1. Single request: req 2 data 8'hA5, rx_ready=1.
//     -> bits 1,0,1,0,1,0,0,1,0,1; tx_src=2; tx_finish at T+11.
//  2. All four req_valid asserted right after reset.
//     -> grants in order 0,1,2,3; four tx_finish pulses; each req_ready is 1 cycle.
//  3. Backpressure: rx_ready 1,0,0,1,... during SHIFT.
//     -> tx_data and tx_valid stable while 0; still exactly 10 accepted bits.
//  4. Pointer wrap: grant 3 completes, then req 0 and req 3 valid together.
//     -> req 0 granted first.
//  5. rst_n pulsed low at bit 5 of a frame.
//     -> tx_valid=0 the same cycle, no tx_finish, state IDLE, ptr=0.
//  6. rx_ready=1 with no requests for 20 cycles.
//     -> tx_valid=0, busy=0, req_ready=0 throughout.

Source files
------------

// File: rtl/tx_link_arbiter_pkg.sv
// Shared types and helpers for the serial TX link blocks: FSM state encoding
// and the frame-width rule {source ID, payload}.
package tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } tx_state_e;

    function automatic int frame_width(input int num_req, input int data_w);
        return $clog2(num_req) + data_w;
    endfunction

endpackage

// File: rtl/tx_link_arbiter_if.sv
// Client request bus plus the serial link toward the receiver.
// The arbiter sits on the slave side; client logic and the receiver drive the master side.
interface tx_link_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rx_ready;
    logic                      tx_data;
    logic                      tx_valid;
    logic                      tx_finish;
    logic [ID_W-1:0]           tx_src;
    logic                      busy;

    modport master (
        output req_valid, req_data, rx_ready,
        input  req_ready, tx_data, tx_valid, tx_finish, tx_src, busy
    );

    modport slave (
        input  req_valid, req_data, rx_ready,
        output req_ready, tx_data, tx_valid, tx_finish, tx_src, busy
    );

endinterface

// File: rtl/tx_link_arbiter_rr.sv
// Round-robin arbiter: combinational grant starting the search at ptr, and the
// registered pointer, which moves past the winner whenever a grant is taken.
module tx_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               advance,
    output logic               grant_vld,
    output logic [ID_W-1:0]    grant_idx,
    output logic [NUM_REQ-1:0] grant_oh
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    // Scan from the farthest offset down so the requester nearest ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[ID_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        grant_oh = '0;
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_vld) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tx_link_arbiter.sv
// Shares one serial TX link among NUM_REQ word clients: round-robin grant,
// {source ID, data} framing, MSB-first shifting under rx_ready backpressure.
module tx_link_arbiter
    import tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input logic              clk,
    input logic              rst_n,
    tx_link_arbiter_if.slave link
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int FRAME_W = frame_width(NUM_REQ, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W);

    tx_state_e          state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    src_q, src_d;
    logic               tx_valid_q, tx_valid_d;

    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [DATA_W-1:0]  grant_data;
    logic               bit_accept;
    logic               last_bit;

    tx_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (link.req_valid),
        .advance   (state_q == TX_IDLE),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh)
    );

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) grant_data = link.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign bit_accept = tx_valid_q && link.rx_ready;
    assign last_bit   = (cnt_q == CNT_W'(FRAME_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            src_q      <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:  if (grant_vld) state_d = TX_SHIFT;
            TX_SHIFT: if (bit_accept && last_bit) state_d = TX_DONE;
            TX_DONE:  state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    // Shifting left with zero fill leaves shreg clear after a frame, so tx_data idles low.
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        tx_valid_d = tx_valid_q;
        unique case (state_q)
            TX_IDLE: begin
                if (grant_vld) begin
                    shreg_d    = {grant_idx, grant_data};
                    cnt_d      = '0;
                    src_d      = grant_idx;
                    tx_valid_d = 1'b1;
                end
            end
            TX_SHIFT: begin
                if (bit_accept) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                    if (last_bit) tx_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        link.req_ready = (state_q == TX_IDLE) ? grant_oh : '0;
        link.tx_valid  = tx_valid_q;
        link.tx_data   = shreg_q[FRAME_W-1];
        link.tx_finish = (state_q == TX_DONE);
        link.tx_src    = src_q;
        link.busy      = (state_q != TX_IDLE);
    end

endmodule

// File: tb/tb_tx_link_arbiter.sv
// Self-checking bench for tx_link_arbiter: directed scenarios plus randomized
// traffic against a frame-level reference model.
module tb_tx_link_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;
    localparam int FRAME_W = ID_W + DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_link_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) link ();

    tx_link_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    int tests = 0;
    int fails = 0;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [NUM_REQ-1:0] m;
            m = v >> ((ptr + k) % NUM_REQ);
            if (m[0]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [FRAME_W-1:0] make_frame(input int id, input logic [DATA_W-1:0] d);
        return FRAME_W'(id * (1 << DATA_W) + int'(d));
    endfunction

    task automatic do_reset();
        link.req_valid = '0;
        link.req_data  = '0;
        link.rx_ready  = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        link.req_valid = '0;
        link.req_data  = '0;
        link.rx_ready  = 1'b1;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (link.tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", link.tx_valid); end
        tests++;
        if (link.tx_data !== 1'b0) begin fails++; $display("FAIL reset_tx_data got %b want 0", link.tx_data); end
        tests++;
        if (link.tx_finish !== 1'b0) begin fails++; $display("FAIL reset_tx_finish got %b want 0", link.tx_finish); end
        tests++;
        if (link.tx_src !== 2'd0) begin fails++; $display("FAIL reset_tx_src got %0d want 0", link.tx_src); end
        tests++;
        if (link.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", link.busy); end
        tests++;
        if (link.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b want 0000", link.req_ready); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [FRAME_W-1:0] exp_bits;
        int t;
        int extra_fin;
        exp_bits  = 10'b1010100101;
        t         = -1;
        extra_fin = 0;
        do_reset();
        link.rx_ready             = 1'b1;
        link.req_data[2*DATA_W +: DATA_W] = 8'hA5;
        link.req_valid            = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (t < 0 && link.req_ready !== 4'b0000) begin
                t = c;
                tests++;
                if (link.req_ready !== 4'b0100) begin fails++; $display("FAIL single_grant got %b want 0100", link.req_ready); end
            end else if (t >= 0 && c <= t + FRAME_W) begin
                tests++;
                if (link.tx_valid !== 1'b1 || link.tx_data !== exp_bits[FRAME_W-(c-t)] || link.tx_src !== 2'd2) begin
                    fails++;
                    $display("FAIL single_bit%0d got v=%b d=%b src=%0d want v=1 d=%b src=2",
                             c - t, link.tx_valid, link.tx_data, link.tx_src, exp_bits[FRAME_W-(c-t)]);
                end
            end else if (t >= 0 && c == t + FRAME_W + 1) begin
                tests++;
                if (link.tx_finish !== 1'b1 || link.tx_valid !== 1'b0 || link.tx_src !== 2'd2) begin
                    fails++;
                    $display("FAIL single_finish got fin=%b v=%b src=%0d want fin=1 v=0 src=2",
                             link.tx_finish, link.tx_valid, link.tx_src);
                end
            end else if (t >= 0 && c == t + FRAME_W + 2) begin
                tests++;
                if (link.busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b want 0", link.busy); end
            end
            if (link.tx_finish === 1'b1 && (t < 0 || c != t + FRAME_W + 1)) extra_fin++;
            @(posedge clk);
            #1;
            if (t >= 0) begin
                link.req_valid                   = '0;
                link.req_data[2*DATA_W +: DATA_W] = 8'h3C;
            end
        end
        tests++;
        if (t < 0) begin fails++; $display("FAIL single_timeout got no grant want grant of req 2"); end
        tests++;
        if (extra_fin != 0) begin fails++; $display("FAIL single_stray_finish got %0d want 0", extra_fin); end
    endtask

    task automatic test_all_four();
        int order[$];
        int rdy_cnt[NUM_REQ];
        int fin;
        int g;
        fin = 0;
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
        do_reset();
        link.rx_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) link.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        link.req_valid = 4'b1111;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            g = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (link.req_ready[i] === 1'b1) begin
                    g = i;
                    rdy_cnt[i]++;
                end
            end
            if (g >= 0) order.push_back(g);
            if (link.tx_finish === 1'b1) fin++;
            @(posedge clk);
            #1;
            if (g >= 0) link.req_valid[g] = 1'b0;
        end
        tests++;
        if (order.size() != 4) begin fails++; $display("FAIL all4_grant_count got %0d want 4", order.size()); end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            tests++;
            if (order[i] != i) begin fails++; $display("FAIL all4_order[%0d] got %0d want %0d", i, order[i], i); end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            tests++;
            if (rdy_cnt[i] != 1) begin fails++; $display("FAIL all4_ready_cycles[%0d] got %0d want 1", i, rdy_cnt[i]); end
        end
        tests++;
        if (fin != 4) begin fails++; $display("FAIL all4_finish_pulses got %0d want 4", fin); end
    endtask

    task automatic test_backpressure();
        logic [3:0]        seq;
        logic [DATA_W-1:0] d;
        logic [FRAME_W-1:0] got;
        int   nacc;
        int   fin;
        bit   granted;
        logic prev_v, prev_d, prev_r;
        seq     = 4'b1001;
        d       = DATA_W'($urandom);
        got     = '0;
        nacc    = 0;
        fin     = 0;
        granted = 1'b0;
        prev_v  = 1'b0;
        prev_d  = 1'b0;
        prev_r  = 1'b1;
        do_reset();
        link.rx_ready                     = seq[0];
        link.req_data[1*DATA_W +: DATA_W] = d;
        link.req_valid                    = 4'b0010;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (link.req_ready[1] === 1'b1) granted = 1'b1;
            if (prev_v === 1'b1 && prev_r === 1'b0) begin
                tests++;
                if (link.tx_valid !== 1'b1 || link.tx_data !== prev_d) begin
                    fails++;
                    $display("FAIL bp_hold cyc%0d got v=%b d=%b want v=1 d=%b", c, link.tx_valid, link.tx_data, prev_d);
                end
            end
            if (link.tx_valid === 1'b1 && link.rx_ready === 1'b1) begin
                got = {got[FRAME_W-2:0], link.tx_data};
                nacc++;
            end
            if (link.tx_finish === 1'b1) fin++;
            prev_v = link.tx_valid;
            prev_d = link.tx_data;
            prev_r = link.rx_ready;
            @(posedge clk);
            #1;
            if (granted) link.req_valid = '0;
            link.rx_ready = seq[(c + 1) % 4];
        end
        tests++;
        if (nacc != FRAME_W) begin fails++; $display("FAIL bp_bit_count got %0d want %0d", nacc, FRAME_W); end
        tests++;
        if (got !== make_frame(1, d)) begin fails++; $display("FAIL bp_frame got %h want %h", got, make_frame(1, d)); end
        tests++;
        if (fin != 1) begin fails++; $display("FAIL bp_finish got %0d want 1", fin); end
    endtask

    task automatic test_ptr_wrap();
        bit granted;
        bit finished;
        granted  = 1'b0;
        finished = 1'b0;
        do_reset();
        link.rx_ready                     = 1'b1;
        link.req_data[3*DATA_W +: DATA_W] = DATA_W'($urandom);
        link.req_data[0*DATA_W +: DATA_W] = DATA_W'($urandom);
        link.req_valid                    = 4'b1000;
        for (int c = 0; c < 30 && !finished; c++) begin
            @(negedge clk);
            if (!granted && link.req_ready !== 4'b0000) begin
                granted = 1'b1;
                tests++;
                if (link.req_ready !== 4'b1000) begin fails++; $display("FAIL wrap_first_grant got %b want 1000", link.req_ready); end
            end
            if (link.tx_finish === 1'b1) finished = 1'b1;
            @(posedge clk);
            #1;
            if (granted) link.req_valid = '0;
        end
        tests++;
        if (!finished) begin fails++; $display("FAIL wrap_timeout got no tx_finish want one frame"); end
        link.req_valid = 4'b1001;
        @(negedge clk);
        tests++;
        if (link.req_ready !== 4'b0001) begin fails++; $display("FAIL wrap_second_grant got %b want 0001", link.req_ready); end
        @(posedge clk);
        #1 link.req_valid = '0;
    endtask

    task automatic test_reset_midframe();
        int t;
        int stray;
        t     = -1;
        stray = 0;
        do_reset();
        link.rx_ready                     = 1'b1;
        link.req_data[1*DATA_W +: DATA_W] = DATA_W'($urandom);
        link.req_valid                    = 4'b0010;
        for (int c = 0; c < 20 && !(t >= 0 && c > t + 5); c++) begin
            @(negedge clk);
            if (t < 0 && link.req_ready[1] === 1'b1) t = c;
            if (t >= 0 && c == t + 5) begin
                rst_n = 1'b0;
                #1;
                tests++;
                if (link.tx_valid !== 1'b0 || link.tx_finish !== 1'b0 || link.busy !== 1'b0 ||
                    link.tx_data !== 1'b0 || link.tx_src !== 2'd0) begin
                    fails++;
                    $display("FAIL midrst_outputs got v=%b fin=%b busy=%b d=%b src=%0d want all 0",
                             link.tx_valid, link.tx_finish, link.busy, link.tx_data, link.tx_src);
                end
            end else begin
                @(posedge clk);
                #1;
                if (t >= 0) link.req_valid = '0;
            end
        end
        tests++;
        if (t < 0) begin fails++; $display("FAIL midrst_timeout got no grant want grant of req 1"); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        link.req_valid = '0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (link.tx_finish === 1'b1 || link.busy === 1'b1 || link.tx_valid === 1'b1) stray++;
        end
        tests++;
        if (stray != 0) begin fails++; $display("FAIL midrst_after got %0d active cycles want 0", stray); end
        @(posedge clk);
        #1 link.req_valid = 4'b1001;
        @(negedge clk);
        tests++;
        if (link.req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_ptr got %b want 0001", link.req_ready); end
        @(posedge clk);
        #1 link.req_valid = '0;
    endtask

    task automatic test_idle();
        do_reset();
        link.rx_ready  = 1'b1;
        link.req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests++;
            if ({link.tx_valid, link.busy, link.req_ready, link.tx_finish} !== 7'd0) begin
                fails++;
                $display("FAIL idle cyc%0d got v=%b busy=%b rdy=%b fin=%b want all 0",
                         c, link.tx_valid, link.busy, link.req_ready, link.tx_finish);
            end
        end
    endtask

    task automatic test_random_traffic();
        logic [DATA_W-1:0]  pend[NUM_REQ][$];
        logic [FRAME_W-1:0] m_frame;
        int m_ptr, m_phase, m_idx, m_src, g, nerr;
        logic [NUM_REQ-1:0] exp_rdy;
        m_ptr   = 0;
        m_phase = 0;
        m_idx   = 0;
        m_src   = 0;
        m_frame = '0;
        nerr    = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i].size() == 0 && $urandom_range(0, 5) == 0) pend[i].push_back(DATA_W'($urandom));
                link.req_valid[i] = (pend[i].size() > 0) && ($urandom_range(0, 3) != 0);
                link.req_data[i*DATA_W +: DATA_W] = (pend[i].size() > 0) ? pend[i][0] : DATA_W'($urandom);
            end
            link.rx_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            case (m_phase)
                0: begin
                    g       = rr_pick(link.req_valid, m_ptr);
                    exp_rdy = (g >= 0) ? NUM_REQ'(1 << g) : '0;
                    tests++;
                    if (link.req_ready !== exp_rdy || link.tx_valid !== 1'b0 || link.tx_finish !== 1'b0 || link.busy !== 1'b0) begin
                        fails++;
                        nerr++;
                        if (nerr < 10) $display("FAIL rand_idle cyc%0d got rdy=%b v=%b fin=%b busy=%b want rdy=%b v=0 fin=0 busy=0",
                                                c, link.req_ready, link.tx_valid, link.tx_finish, link.busy, exp_rdy);
                    end
                    if (g >= 0) begin
                        m_frame = make_frame(g, pend[g][0]);
                        void'(pend[g].pop_front());
                        m_src   = g;
                        m_idx   = 0;
                        m_ptr   = (g + 1) % NUM_REQ;
                        m_phase = 1;
                    end
                end
                1: begin
                    tests++;
                    if (link.tx_valid !== 1'b1 || link.tx_data !== m_frame[FRAME_W-1-m_idx] ||
                        link.tx_src !== ID_W'(m_src) || link.busy !== 1'b1 ||
                        link.req_ready !== '0 || link.tx_finish !== 1'b0) begin
                        fails++;
                        nerr++;
                        if (nerr < 10) $display("FAIL rand_shift cyc%0d bit%0d got v=%b d=%b src=%0d want v=1 d=%b src=%0d",
                                                c, m_idx, link.tx_valid, link.tx_data, link.tx_src, m_frame[FRAME_W-1-m_idx], m_src);
                    end
                    if (link.rx_ready === 1'b1) begin
                        m_idx++;
                        if (m_idx == FRAME_W) m_phase = 2;
                    end
                end
                default: begin
                    tests++;
                    if (link.tx_finish !== 1'b1 || link.tx_valid !== 1'b0 || link.tx_src !== ID_W'(m_src) ||
                        link.busy !== 1'b1 || link.req_ready !== '0) begin
                        fails++;
                        nerr++;
                        if (nerr < 10) $display("FAIL rand_done cyc%0d got fin=%b v=%b src=%0d want fin=1 v=0 src=%0d",
                                                c, link.tx_finish, link.tx_valid, link.tx_src, m_src);
                    end
                    m_phase = 0;
                end
            endcase
            @(posedge clk);
            #1;
        end
        link.req_valid = '0;
    endtask

    initial begin
        link.req_valid = '0;
        link.req_data  = '0;
        link.rx_ready  = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_ptr_wrap();
        test_reset_midframe();
        test_idle();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want summary before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
